button_event: RTL
=================

// Module: button_event
// PURPOSE
//  Per-button event generator sitting directly downstream of the debouncer: consumes clean,
//  clk-synchronous button levels and produces single-cycle press/release pulses, a held flag and
//  hold-to-repeat pulses, so tank move/fire logic sees one action per tap plus a steady auto-repeat.
//  Channels are fully independent; all outputs are registered.
// PARAMETERS
//  N_BTN       2           number of button channels (>=1)
//  DLY_W       26          width of per-channel delay counter
//  INIT_DLY    40_000_000  cycles from press pulse to first repeat pulse (>=1, < 2**DLY_W)
//  RPT_PERIOD  10_000_000  cycles between successive repeat pulses (>=1, < 2**DLY_W)
// PORTS
//  clk        in   1      system clock, same domain as debouncer
//  rst        in   1      synchronous, active-high reset
//  btn        in   N_BTN  debounced button levels, 1 = pressed (debouncer O0 -> btn[0], O1 -> btn[1])
//  btn_press  out  N_BTN  1-cycle pulse on press detection
//  btn_rpt    out  N_BTN  1-cycle pulse per auto-repeat tick while held
//  btn_rel    out  N_BTN  1-cycle pulse on release detection
//  btn_held   out  N_BTN  level, 1 while channel state != IDLE
//  btn_evt    out  N_BTN  btn_press | btn_rpt (registered together, same cycle)
// BEHAVIOUR
//  - Reset: every state = IDLE, cnt = 0, all outputs 0. Reset mid-hold aborts with no btn_rel.
//  - Per-channel FSM, evaluated each posedge clk:
//    IDLE : btn=1 -> btn_press=1, cnt<=0, go WAIT. btn=0 -> stay.
//    WAIT : btn=0 -> btn_rel=1, go IDLE. Else if cnt==INIT_DLY-1 -> btn_rpt=1, cnt<=0,
//           go RPT. Else cnt<=cnt+1.
//    RPT  : btn=0 -> btn_rel=1, go IDLE. Else if cnt==RPT_PERIOD-1 -> btn_rpt=1, cnt<=0.
//           Else cnt<=cnt+1.
//  - Latency: btn sampled 1 at edge k -> btn_press high for cycle after edge k (call cycle t).
//    First btn_rpt in cycle t+INIT_DLY, then every RPT_PERIOD cycles while btn stays 1.
//  - Pulses are exactly one cycle and are cleared the cycle after they are asserted.
//  - btn_held goes 1 in cycle t and goes 0 in the same cycle btn_rel is asserted.
//  - Release on the edge where cnt hits its terminal value: release wins, no btn_rpt.
//  - btn_press and btn_rel never assert in the same cycle on one channel. Min tap (btn=1 one
//    cycle) -> btn_press in t, btn_rel in t+1.
//  - btn already 1 when rst deasserts: treated as a new press (btn_press on first active edge).
//  - Counter never wraps: reset to 0 at every terminal count; width check by parameter bounds.
//  - Channels share nothing; simultaneous events on different channels all reported same cycle.
//  - btn must already be synchronous to clk; this block adds no synchroniser or filtering.
// STRUCTURE
//  - button_event_pkg.vh (shared include): state encodings ST_IDLE=2'd0, ST_WAIT=2'd1,
//    ST_RPT=2'd2 (2'd3 illegal -> recovers to IDLE), and default timing constants for 100 MHz.
//  - Sub-module button_event_ch: one FSM + DLY_W counter + 3 pulse regs, single-bit btn.
//    The top generate-loops N_BTN instances and packs outputs. btn_evt is OR'd per channel from
//    next-state values so it is registered alongside the pulses.
// TESTING (override INIT_DLY=5, RPT_PERIOD=3, N_BTN=2)
//  1. rst=1 4 cycles with btn=2'b11 -> all outputs 0. Release rst -> btn_press=2'b11 next cycle.
//  2. btn[0] 0->1 held 20 cycles -> btn_press[0] at t, btn_rpt[0] at t+5, t+8, t+11, t+14,
//     t+17; btn_rel[0] one cycle after btn drops. btn_held[0]=1 from t to the cycle before btn_rel.
//  3. btn[0] high 1 cycle -> btn_press at t, btn_rel at t+1, no btn_rpt; btn_held high 1 cycle.
//  4. btn[0] drops on the edge where the first repeat is due (cycle t+5) -> btn_rel only, no btn_rpt.
//  5. btn[1] held while btn[0] taps -> channel 1 repeat cadence unchanged; btn_evt == press|rpt
//     on both bits every cycle.
//  6. Assert rst during RPT -> next cycle all outputs 0 and no btn_rel. btn still 1 after rst
//     deasserts -> fresh btn_press and the INIT_DLY sequence restarts.

Source files
------------

// File: rtl/button_event_pkg.sv
// rtl/button_event_pkg.sv - shared state encodings and default timing for button_event
package button_event_pkg;

    // Per-channel FSM encoding; 2'd3 is unused and falls back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    // Defaults sized for a 100 MHz clock: 0.4 s to first repeat, then every 0.1 s
    localparam int DEF_N_BTN      = 2;
    localparam int DEF_DLY_W      = 26;
    localparam int DEF_INIT_DLY   = 40_000_000;
    localparam int DEF_RPT_PERIOD = 10_000_000;

endpackage

// File: rtl/button_event_ch.sv
// rtl/button_event_ch.sv - single-channel press/repeat/release event FSM
module button_event_ch
    import button_event_pkg::*;
#(
    parameter int DLY_W      = DEF_DLY_W,
    parameter int INIT_DLY   = DEF_INIT_DLY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic rpt,
    output logic rel,
    output logic held,
    output logic evt
);

    // Terminal counts; the counter restarts at 0 on every terminal so it never wraps
    localparam logic [DLY_W-1:0] INIT_LAST = DLY_W'(INIT_DLY - 1);
    localparam logic [DLY_W-1:0] RPT_LAST  = DLY_W'(RPT_PERIOD - 1);
    localparam logic [DLY_W-1:0] CNT_ONE   = DLY_W'(1);

    state_t           state;
    logic [DLY_W-1:0] cnt;

    // FSM with registered outputs; release always takes priority over a due repeat
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rpt   <= 1'b0;
            rel   <= 1'b0;
            held  <= 1'b0;
            evt   <= 1'b0;
        end else begin
            press <= 1'b0;
            rpt   <= 1'b0;
            rel   <= 1'b0;
            evt   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn) begin
                        press <= 1'b1;
                        evt   <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        held  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!btn) begin
                        rel   <= 1'b1;
                        held  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == INIT_LAST) begin
                        rpt   <= 1'b1;
                        evt   <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_RPT;
                    end else begin
                        held  <= 1'b1;
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                ST_RPT: begin
                    if (!btn) begin
                        rel   <= 1'b1;
                        held  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == RPT_LAST) begin
                        rpt   <= 1'b1;
                        evt   <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        held  <= 1'b1;
                        cnt   <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    held  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event.sv
// rtl/button_event.sv - N-channel button event generator (press, repeat, release, held)
module button_event
    import button_event_pkg::*;
#(
    parameter int N_BTN      = DEF_N_BTN,
    parameter int DLY_W      = DEF_DLY_W,
    parameter int INIT_DLY   = DEF_INIT_DLY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_rpt,
    output logic [N_BTN-1:0] btn_rel,
    output logic [N_BTN-1:0] btn_held,
    output logic [N_BTN-1:0] btn_evt
);

    // One independent channel per button; outputs are packed bit-per-channel
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_event_ch #(
            .DLY_W      (DLY_W),
            .INIT_DLY   (INIT_DLY),
            .RPT_PERIOD (RPT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .press (btn_press[i]),
            .rpt   (btn_rpt[i]),
            .rel   (btn_rel[i]),
            .held  (btn_held[i]),
            .evt   (btn_evt[i])
        );
    end

endmodule
